// File: rtl/fetch_redirect_controller.sv
// fetch_redirect_controller: arbitrates branch, JAL and predictor redirects into
// the PC select stage, parks a redirect while the back end is stalled, and opens
// a wrong-path kill window after every branch redirect.
//
// state  | meaning
// IDLE   | no redirect pending; requests issue next cycle or park in HOLD on stall
// HOLD   | JAL/predictor redirect parked until the stall clears
// KILL   | wrong-path window after a branch redirect; JAL/predictor discarded
module fetch_redirect_controller #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             brValid,
  input  logic [WIDTH-1:0] brTarget,
  input  logic             jalValid,
  input  logic [WIDTH-1:0] jalTarget,
  input  logic             predHit,
  input  logic [WIDTH-1:0] predTarget,
  input  logic             robFull,
  input  logic             rsFull,
  output logic             redirValid,
  output logic [WIDTH-1:0] redirTarget,
  output logic [1:0]       redirSrc,
  output logic             predRedirect,
  output logic             flushFrontend,
  output logic             freeze
);

  localparam int KCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [KCW-1:0] KILL_LOAD = KCW'(FLUSH_CYCLES);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BR   = 2'd1;
  localparam logic [1:0] SRC_JAL  = 2'd2;
  localparam logic [1:0] SRC_PRED = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  state_t           r_state;
  logic [KCW-1:0]   r_kill_cnt;
  logic [WIDTH-1:0] r_pend_target;
  logic [1:0]       r_pend_src;
  logic             r_redir_valid;
  logic [WIDTH-1:0] r_redir_target;
  logic [1:0]       r_redir_src;
  logic             r_pred_redirect;
  logic             r_flush;

  logic             w_stall;
  logic             w_req;
  logic [1:0]       w_req_src;
  logic [WIDTH-1:0] w_req_target;
  logic             w_issue;
  logic [1:0]       w_iss_src;
  logic [WIDTH-1:0] w_iss_target;

  assign w_stall = robFull | rsFull;

  // Highest-priority non-branch request this cycle (JAL beats predictor).
  always_comb begin
    w_req        = jalValid | predHit;
    w_req_src    = SRC_NONE;
    w_req_target = '0;
    if (jalValid) begin
      w_req_src    = SRC_JAL;
      w_req_target = jalTarget;
    end else if (predHit) begin
      w_req_src    = SRC_PRED;
      w_req_target = predTarget;
    end
  end

  // Decide which redirect, if any, issues on the next cycle.
  always_comb begin
    w_issue      = 1'b0;
    w_iss_src    = SRC_NONE;
    w_iss_target = '0;
    if (brValid) begin
      w_issue      = 1'b1;
      w_iss_src    = SRC_BR;
      w_iss_target = brTarget;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && !w_stall) begin
            w_issue      = 1'b1;
            w_iss_src    = w_req_src;
            w_iss_target = w_req_target;
          end
        end
        ST_HOLD: begin
          if (!w_stall) begin
            w_issue = 1'b1;
            // A JAL arriving as the stall clears outranks a parked predictor hit.
            if (jalValid && r_pend_src == SRC_PRED) begin
              w_iss_src    = SRC_JAL;
              w_iss_target = jalTarget;
            end else begin
              w_iss_src    = r_pend_src;
              w_iss_target = r_pend_target;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, pending slot, kill counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_kill_cnt      <= '0;
      r_pend_target   <= '0;
      r_pend_src      <= SRC_NONE;
      r_redir_valid   <= 1'b0;
      r_redir_target  <= '0;
      r_redir_src     <= SRC_NONE;
      r_pred_redirect <= 1'b0;
      r_flush         <= 1'b0;
    end else begin
      r_redir_valid   <= w_issue;
      r_redir_src     <= w_iss_src;
      r_pred_redirect <= w_issue && (w_iss_src == SRC_PRED);
      r_flush         <= w_issue && (w_iss_src == SRC_BR);
      if (w_issue) begin
        r_redir_target <= w_iss_target;
      end

      if (brValid) begin
        r_state       <= ST_KILL;
        r_kill_cnt    <= KILL_LOAD;
        r_pend_src    <= SRC_NONE;
        r_pend_target <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_req && w_stall) begin
              r_state       <= ST_HOLD;
              r_pend_src    <= w_req_src;
              r_pend_target <= w_req_target;
            end
          end
          ST_HOLD: begin
            if (!w_stall) begin
              r_state       <= ST_IDLE;
              r_pend_src    <= SRC_NONE;
              r_pend_target <= '0;
            end else if (jalValid && r_pend_src == SRC_PRED) begin
              r_pend_src    <= SRC_JAL;
              r_pend_target <= jalTarget;
            end
          end
          ST_KILL: begin
            if (r_kill_cnt <= KCW'(1)) begin
              r_state    <= ST_IDLE;
              r_kill_cnt <= '0;
            end else begin
              r_kill_cnt <= r_kill_cnt - KCW'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign redirValid    = r_redir_valid;
  assign redirTarget   = r_redir_target;
  assign redirSrc      = r_redir_src;
  assign predRedirect  = r_pred_redirect;
  assign flushFrontend = r_flush;
  // The PC must always be free to take a redirect, so a redirect cycle never freezes.
  assign freeze        = (w_stall & ~r_redir_valid) | (r_state == ST_HOLD);

endmodule

// File: doc/fetch_redirect_controller.md
# fetch_redirect_controller

Sequences all front-end PC redirects into the PC select stage. Arbitrates branch-resolution, rename-stage JAL and branch-predictor redirect requests, holds a pending redirect while the back end stalls, and generates the frontend flush pulse and wrong-path kill window. Outputs drive the PC select stage's redirect, target and freeze inputs and the fetch/decode pipeline clears.

## Interface
- WIDTH, 32, address width in bits (word addresses)
- FLUSH_CYCLES, 2, cycles after a branch redirect during which JAL/predictor requests are discarded as wrong-path (≥1)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- brValid  in  1  branch unit reports mispredict or misdirect this cycle
- brTarget  in  WIDTH  corrected PC for brValid
- jalValid  in  1  rename stage has a JAL this cycle
- jalTarget  in  WIDTH  JAL target
- predHit  in  1  predictor hit for current fetch PC
- predTarget  in  WIDTH  predicted PC
- robFull  in  1  ROB has no free entry
- rsFull  in  1  reservation stations have no free entry
- redirValid  out  1  one-cycle pulse: load redirTarget as next PC
- redirTarget  out  WIDTH  PC to load when redirValid
- redirSrc  out  2  source of issued redirect: 0 none, 1 branch, 2 JAL, 3 predictor
- predRedirect  out  1  redirValid with redirSrc==3 (feeds decode redirect flag)
- flushFrontend  out  1  one-cycle pulse with every branch redirect; clears fetch and decode
- freeze  out  1  holds PC register

## Operation
- Priority: branch > JAL > predictor. Only one request accepted per cycle; losers in the same cycle are dropped (younger instructions, refetched or flushed).
- States: IDLE, HOLD, KILL. Counter killCnt, width clog2(FLUSH_CYCLES+1).
- stall = robFull | rsFull (combinational).
- IDLE:
  - brValid → issue branch redirect next cycle; go KILL, killCnt = FLUSH_CYCLES.
  - else jalValid/predHit, stall=0 → issue redirect next cycle, stay IDLE.
  - else jalValid/predHit, stall=1 → latch target and source into pending register, go HOLD.
- HOLD:
  - brValid → discard pending, issue branch redirect, go KILL.
  - stall=0 → issue pending redirect, go IDLE.
  - new jalValid/predHit while pending: replace pending only if strictly higher priority (JAL replaces predictor); otherwise ignored.
- KILL:
  - jalValid and predHit ignored entirely.
  - killCnt decrements each cycle; at 1 → IDLE next cycle.
  - brValid → issue new branch redirect, reload killCnt = FLUSH_CYCLES.
- Branch redirects issue regardless of stall.
- freeze = stall & ~redirValid; also 1 in HOLD. A redirect cycle never freezes (PC must take redirTarget).
- redirTarget holds last issued value when redirValid=0; consumers qualify with redirValid.

## Timing
- All outputs except freeze registered; request in cycle N → redirValid, redirTarget, redirSrc, flushFrontend in cycle N+1, for exactly one cycle.
- freeze combinational from stall, state and redirValid.
- Reset (any cycle, including HOLD/KILL): state IDLE, pending cleared, killCnt 0, redirValid 0, redirTarget 0, redirSrc 0, predRedirect 0, flushFrontend 0; freeze follows stall only. Request inputs in the reset cycle ignored.
- Back-to-back brValid every cycle: a redirect pulse every cycle, each the latest target; KILL persists.
- Stall drops in same cycle as new jalValid in HOLD: issue the higher-priority of pending vs new; the other is dropped.
- Branch redirect cycle: flushFrontend=1, redirSrc=1; no other source sets flushFrontend.

## Test plan
- Priority: cycle 5 brValid=1 brTarget=0x40, jalValid=1 jalTarget=0x80, predHit=1 → cycle 6 redirValid=1, redirTarget=0x40, redirSrc=1, flushFrontend=1; no further pulse.
- Kill window (FLUSH_CYCLES=2): brValid target 0x10 at cycle 3, jalValid target 0x90 at cycles 4 and 5 → single redirect 0x10 at cycle 4; JAL ignored; jalValid at cycle 6 → redirect 0x90 at cycle 7.
- Stall hold: robFull=1 cycles 2-6, predHit target 0x20 at cycle 2, jalValid target 0x30 at cycle 4 → freeze=1 cycles 2-6, redirValid=0; robFull drops cycle 7 → redirect 0x30, redirSrc=2 at cycle 8.
- Branch overrides stall: rsFull=1, pending JAL 0x30 in HOLD, brValid target 0x44 → next cycle redirect 0x44, redirSrc=1, freeze=0 that cycle; pending discarded, no later 0x30 pulse.
- Predictor path: predHit target 0x100, no stall → next cycle redirValid=1, predRedirect=1, flushFrontend=0.
- Reset mid-HOLD: pending predictor 0x20, reset=1 one cycle then stall drops → no redirect ever issued; all outputs 0 after reset.
